ibex_csr_rmw_ctrl: RTL and testbench
====================================

// Module: ibex_csr_rmw_ctrl
// PURPOSE
//  Access-side controller for a single ibex_csr shadowed register: accepts CSR
//  ops (read/write/set/clear) on a valid/ready request channel, samples the
//  register, computes the new value, pulses the write strobe and returns the
//  old value on a valid/ready response channel. Sits between the CSR decode
//  stage and one ibex_csr instance; flags shadow-copy integrity errors.
// PARAMETERS
//  Width    32   data width of request, response and CSR ports
//  LockBit  31   bit index of lock flag in stored value (IBEX_CSR_RMW_LOCK_EN only)
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_i          in   1      asynchronous, active-high reset
//  req_valid_i    in   1      request valid
//  req_ready_o    out  1      request ready (high only in IDLE)
//  req_op_i       in   2      00 READ, 01 WRITE, 10 SET, 11 CLEAR
//  req_wdata_i    in   Width  write data / set-clear mask
//  rsp_valid_o    out  1      response valid
//  rsp_ready_i    in   1      response ready
//  rsp_rdata_o    out  Width  CSR value before the op
//  rsp_error_o    out  1      integrity error (or lock violation)
//  csr_rd_data_i  in   Width  ibex_csr rd_data_o
//  csr_rd_error_i in   1      ibex_csr rd_error_o
//  csr_wr_en_o    out  1      ibex_csr wr_en_i, single-cycle pulse
//  csr_wr_data_o  out  Width  ibex_csr wr_data_i
// BEHAVIOUR
//  - Reset: state IDLE; req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0,
//    rsp_error_o=0, csr_wr_en_o=0, csr_wr_data_o=0; captured op/data cleared.
//  - FSM IDLE -> SAMPLE -> [WRITE] -> RESP -> IDLE.
//  - IDLE: req_valid_i&req_ready_o captures op and wdata; next SAMPLE.
//  - SAMPLE: register csr_rd_data_i as old, csr_rd_error_i as err.
//    new = WRITE: wdata; SET: old|wdata; CLEAR: old&~wdata.
//    Go WRITE iff op!=READ, err=0, and not (SET/CLEAR with wdata==0); else RESP.
//  - WRITE: csr_wr_en_o=1 for exactly one cycle, csr_wr_data_o=new; next RESP.
//    csr_wr_data_o returns to 0 when csr_wr_en_o is low.
//  - RESP: rsp_valid_o=1, rsp_rdata_o=old, rsp_error_o=err; held stable until
//    rsp_ready_i; on handshake -> IDLE (req_ready_o high next cycle).
//  - Latency (req accept edge = cycle 0): rsp_valid_o high at cycle 2 when no
//    write, cycle 3 when a write is issued. Throughput 1 op per 3-4 cycles.
//  - rsp_ready_i held high: response lasts one cycle; back-to-back requests
//    accepted on the cycle after the response handshake.
//  - Error: old value still returned; no write issued; rsp_error_o=1.
//  - Set/clear with zero mask: pure read, no wr_en pulse (RISC-V CSRRS/C x0).
//  - WRITE with wdata equal to old: write still issued.
//  - Reset mid-op: abort immediately, no wr_en pulse, pending response dropped.
//  - req_op_i/req_wdata_i ignored outside IDLE handshake.
// CONFIGURATION
//  IBEX_CSR_RMW_LOCK_EN defined: in SAMPLE, if old[LockBit]==1 and op would
//    write, write suppressed and rsp_error_o=1 (lock violation); READ and
//    zero-mask SET/CLEAR unaffected. Lock clears only through ibex_csr reset.
//  Not defined: LockBit ignored; all writes proceed per rules above.
// TESTING
//  1 Reset, READ -> rsp_rdata_o=0, rsp_error_o=0, no wr_en, rsp_valid at cycle 2.
//  2 WRITE 0x1234_5678 then READ -> wr_en one pulse with data 0x1234_5678 at
//    cycle 2; READ returns 0x1234_5678; first response rdata=0.
//  3 From 0x0000_00F0: SET 0x0F -> rdata 0xF0, reg 0xFF; CLEAR 0x30 -> rdata
//    0xFF, reg 0xCF; SET 0x0 -> rdata 0xCF, no wr_en pulse.
//  4 Force csr_rd_error_i=1, WRITE 0xAAAA_AAAA -> rsp_error_o=1, no wr_en,
//    reg value unchanged.
//  5 Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid/rdata stable,
//    req_ready_o=0; assert rst_i in WRITE cycle -> no wr_en pulse, IDLE.
//  6 LOCK_EN: WRITE 0x8000_0001, then WRITE 0x0 -> second rsp_error_o=1,
//    READ returns 0x8000_0001; without macro second write succeeds, reads 0x0.

Source files
------------

// File: rtl/ibex_csr_rmw_ctrl.sv
// Read-modify-write access controller for one ibex_csr shadowed register.
// Optional lock-bit write protection is enabled by defining IBEX_CSR_RMW_LOCK_EN.
module ibex_csr_rmw_ctrl #(
    parameter int unsigned Width   = 32,
    parameter int unsigned LockBit = 31
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [Width-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    input  logic [Width-1:0] csr_rd_data_i,
    input  logic             csr_rd_error_i,
    output logic             csr_wr_en_o,
    output logic [Width-1:0] csr_wr_data_o
);

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [Width-1:0] wdata_q, wdata_d;
    logic [Width-1:0] old_q, old_d;
    logic             err_q, err_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             wr_en_q, wr_en_d;
    logic [Width-1:0] wr_data_q, wr_data_d;

    logic [Width-1:0] new_s;
    logic             wants_write_s;
    logic             lock_err_s;

    // New register value and write decision, evaluated against the live CSR read.
    always_comb begin
        new_s = csr_rd_data_i;
        case (op_q)
            OpWrite: new_s = wdata_q;
            OpSet:   new_s = csr_rd_data_i | wdata_q;
            OpClear: new_s = csr_rd_data_i & ~wdata_q;
            default: new_s = csr_rd_data_i;
        endcase
        // Zero-mask set/clear is the CSRRS/CSRRC x0 idiom: a pure read.
        wants_write_s = (op_q != OpRead) && !csr_rd_error_i &&
                        !(op_q[1] && (wdata_q == {Width{1'b0}}));
`ifdef IBEX_CSR_RMW_LOCK_EN
        lock_err_s = wants_write_s && csr_rd_data_i[LockBit];
`else
        lock_err_s = 1'b0;
`endif
    end

    // Next-state logic; every output is registered from the next state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    op_d    = req_op_i;
                    wdata_d = req_wdata_i;
                    state_d = SAMPLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SAMPLE: begin
                old_d = csr_rd_data_i;
                err_d = csr_rd_error_i | lock_err_s;
                if (wants_write_s && !lock_err_s) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        wr_en_d     = (state_d == WRITE);
        wr_data_d   = wr_en_d ? new_s : {Width{1'b0}};
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            wdata_q     <= {Width{1'b0}};
            old_q       <= {Width{1'b0}};
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= {Width{1'b0}};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            old_q       <= old_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = old_q;
    assign rsp_error_o   = err_q;
    assign csr_wr_en_o   = wr_en_q;
    assign csr_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_ibex_csr_rmw_ctrl.sv
// Randomized self-checking bench for ibex_csr_rmw_ctrl with an emulated CSR and
// a transaction-level model of register contents, latency and write pulses.
module tb_ibex_csr_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] csr_rd_data;
    logic        csr_err = 1'b0;
    logic        csr_wr_en;
    logic [31:0] csr_wr_data;

    logic        csr_rst = 1'b1;
    logic [31:0] csr_reg;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_reg = 32'h0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_wr_cnt;

    ibex_csr_rmw_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_error_o   (rsp_error),
        .csr_rd_data_i (csr_rd_data),
        .csr_rd_error_i(csr_err),
        .csr_wr_en_o   (csr_wr_en),
        .csr_wr_data_o (csr_wr_data)
    );

    always #5 clk = ~clk;

    // Emulated ibex_csr storage, reset independently of the controller.
    always @(posedge clk or posedge csr_rst) begin
        if (csr_rst) csr_reg <= 32'h0;
        else if (csr_wr_en) csr_reg <= csr_wr_data;
    end
    assign csr_rd_data = csr_reg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        chk({tag, "_wr_en"}, 32'(csr_wr_en), 32'd0);
        chk({tag, "_wr_data"}, csr_wr_data, 32'h0);
    endtask

    task automatic do_reset(input logic with_csr);
        @(negedge clk);
        rst = 1'b1;
        if (with_csr) csr_rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        csr_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        csr_rst = 1'b0;
        if (with_csr) model_reg = 32'h0;
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    // One transaction, entered and left on a falling edge with the DUT idle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] wd, input logic err, input int hold);
        logic [31:0] old_v = model_reg;
        logic [31:0] new_v;
        logic        do_wr;
        logic        exp_err = err;
        int          rsp_k = -1;
        int          wr_cnt = 0;
        int          wr_k = -1;
        case (op)
            2'b01:   new_v = wd;
            2'b10:   new_v = old_v | wd;
            2'b11:   new_v = old_v & ~wd;
            default: new_v = old_v;
        endcase
        do_wr = (op != 2'b00) && !err && !(op >= 2'b10 && wd == 32'h0);
`ifdef IBEX_CSR_RMW_LOCK_EN
        if (do_wr && old_v[31]) begin
            do_wr = 1'b0;
            exp_err = 1'b1;
        end
`endif
        chk("req_ready_at_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op = op;
        req_wdata = wd;
        csr_err = err;
        rsp_ready = (hold == 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_op = 2'($urandom);
                req_wdata = $urandom;
            end
            if (csr_wr_en) begin
                wr_cnt++;
                wr_k = k;
                chk("wr_data", csr_wr_data, new_v);
            end else begin
                chk("wr_data_low", csr_wr_data, 32'h0);
            end
            if (rsp_valid) begin
                rsp_k = k;
                break;
            end
            chk("req_ready_busy", 32'(req_ready), 32'd0);
        end
        chk("rsp_latency", 32'(rsp_k), do_wr ? 32'd3 : 32'd2);
        chk("wr_pulses", 32'(wr_cnt), 32'(do_wr));
        if (do_wr) chk("wr_cycle", 32'(wr_k), 32'd2);
        chk("rsp_rdata", rsp_rdata, old_v);
        chk("rsp_error", 32'(rsp_error), 32'(exp_err));
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        last_rdata = rsp_rdata;
        last_err = rsp_error;
        last_wr_cnt = wr_cnt;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, old_v);
            chk("hold_error", 32'(rsp_error), 32'(exp_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_wr_en", 32'(csr_wr_en), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'($urandom);
        csr_err = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
        if (do_wr) model_reg = new_v;
        chk("csr_contents", csr_reg, model_reg);
    endtask

    initial begin
        logic [31:0] wd;
        do_reset(1'b1);

        do_op(2'b00, 32'h0, 1'b0, 0);
        chk("t1_rdata", last_rdata, 32'h0);
        chk("t1_no_write", 32'(last_wr_cnt), 32'd0);

        do_op(2'b01, 32'h1234_5678, 1'b0, 0);
        chk("t2_first_rdata", last_rdata, 32'h0);
        do_op(2'b00, 32'h0, 1'b0, 0);
        chk("t2_read_back", last_rdata, 32'h1234_5678);

        do_op(2'b01, 32'h0000_00F0, 1'b0, 0);
        do_op(2'b10, 32'h0000_000F, 1'b0, 0);
        chk("t3_set_rdata", last_rdata, 32'h0000_00F0);
        chk("t3_set_reg", csr_reg, 32'h0000_00FF);
        do_op(2'b11, 32'h0000_0030, 1'b0, 0);
        chk("t3_clr_rdata", last_rdata, 32'h0000_00FF);
        chk("t3_clr_reg", csr_reg, 32'h0000_00CF);
        do_op(2'b10, 32'h0, 1'b0, 1);
        chk("t3_zero_rdata", last_rdata, 32'h0000_00CF);
        chk("t3_zero_nowr", 32'(last_wr_cnt), 32'd0);

        do_op(2'b01, 32'hAAAA_AAAA, 1'b1, 0);
        chk("t4_error", 32'(last_err), 32'd1);
        chk("t4_reg_kept", csr_reg, 32'h0000_00CF);

        do_op(2'b00, 32'h0, 1'b0, 5);
        chk("t5_hold_rdata", last_rdata, 32'h0000_00CF);

        // Reset the controller while it sits in WRITE.
        req_valid = 1'b1;
        req_op = 2'b01;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_abort_wr_en", 32'(csr_wr_en), 32'd0);
        chk("t5_abort_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5_after_abort");
        chk("t5_reg_untouched", csr_reg, 32'h0000_00CF);

        do_reset(1'b1);
        do_op(2'b01, 32'h8000_0001, 1'b0, 0);
        do_op(2'b01, 32'h0, 1'b0, 0);
        do_op(2'b00, 32'h0, 1'b0, 0);
`ifdef IBEX_CSR_RMW_LOCK_EN
        chk("t6_locked_read", last_rdata, 32'h8000_0001);
`else
        chk("t6_unlocked_read", last_rdata, 32'h0);
`endif

        for (int i = 0; i < 60; i++) begin
            if (i % 15 == 0) do_reset(1'($urandom));
            wd = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(7) != 0) wd[31] = 1'b0;
            do_op(2'($urandom), wd, ($urandom_range(7) == 0), int'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
